// File: rtl/alu_issue_buf_pkg.sv
// Shared CPU definitions for the ALU issue buffer: default widths, ALUOp
// encodings and buffer occupancy states.
package alu_issue_buf_pkg;

  localparam int unsigned ALU_DATA_W  = 32;
  localparam int unsigned ALU_OP_W    = 3;
  localparam int unsigned ALU_TAG_W   = 5;
  localparam int unsigned ALU_SHAMT_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_entry.sv
// Single buffer slot: a W-bit register with load enable, cleared on reset.
module alu_issue_entry #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_issue_buf.sv
// Two-entry in-order skid buffer between decode/GRF and the ALU. The head
// slot always drives out_*; the tail slot only holds the second entry.
module alu_issue_buf
  import alu_issue_buf_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned OP_W   = ALU_OP_W,
  parameter int unsigned TAG_W  = ALU_TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [OP_W-1:0]   out_op,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal,
  output logic [1:0]        count
);

  localparam int unsigned ENT_W = 2 * DATA_W + OP_W + TAG_W;

  state_t             state;
  state_t             state_nxt;
  logic               push;
  logic               pop;
  logic               is_shift;
  logic               load_head;
  logic               load_tail;
  logic [DATA_W-1:0]  b_store;
  logic [ENT_W-1:0]   in_ent;
  logic [ENT_W-1:0]   head_d;
  logic [ENT_W-1:0]   head_q;
  logic [ENT_W-1:0]   tail_q;

  // Handshake is decoded purely from the state register.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Shift ops keep only the 5-bit shift amount in B.
  assign is_shift = (in_op == OP_W'(ALU_SRL)) || (in_op == OP_W'(ALU_SRA));
  assign b_store  = is_shift ? DATA_W'(in_b[ALU_SHAMT_W-1:0]) : in_b;
  assign in_ent   = {in_a, b_store, in_op, in_tag};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    load_tail = 1'b0;
    head_d    = in_ent;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state_nxt = ST_ONE;
            load_head = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            load_head = 1'b1;
          end else if (push) begin
            state_nxt = ST_FULL;
            load_tail = 1'b1;
          end else if (pop) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_nxt = ST_ONE;
            load_head = 1'b1;
            head_d    = tail_q;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  alu_issue_entry #(.W(ENT_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .load  (load_head),
    .d     (head_d),
    .q     (head_q)
  );

  alu_issue_entry #(.W(ENT_W)) u_tail (
    .clk   (clk),
    .reset (reset),
    .load  (load_tail),
    .d     (in_ent),
    .q     (tail_q)
  );

  assign {out_a, out_b, out_op, out_tag} = head_q;
  assign out_illegal = out_valid && (out_op[2:1] == 2'b11);
  assign count       = 2'(state);

endmodule
